// File: rtl/sos_pkg.sv
// Shared types and defaults for the sum-of-squares accumulator.
package sos_pkg;

  localparam int unsigned SOS_DATA_W = 16;
  localparam int unsigned SOS_ACC_W  = 32;

  // Element-counter width; a 1-sample vector still needs one bit.
  function automatic int unsigned idx_w(input int unsigned vec_len);
    return (vec_len <= 1) ? 1 : $clog2(vec_len);
  endfunction

  typedef logic [SOS_ACC_W-1:0] sq_t;

  typedef struct packed {
    sq_t  sq;
    logic first;
    logic last;
    logic vld;
  } sq_beat_t;

endpackage

// File: rtl/sum_of_squares_acc_square_stage.sv
// Registered squarer feeding the accumulator; kept separate so the multiplier can be retimed.
module square_stage
  import sos_pkg::*;
#(
  parameter int unsigned DATA_W = SOS_DATA_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic signed [DATA_W-1:0] data_i,
  input  logic                     valid_i,
  input  logic                     first_i,
  input  logic                     last_i,
  output sq_beat_t                 beat_o
);

  logic signed [2*DATA_W-1:0] prod;
  sq_beat_t                   beat_q;

  // A square is never negative, so the signed product reinterprets cleanly as unsigned.
  always_comb prod = data_i * data_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_q <= '0;
    end else begin
      beat_q.vld <= valid_i;
      if (valid_i) begin
        beat_q.sq    <= sq_t'($unsigned(prod));
        beat_q.first <= first_i;
        beat_q.last  <= last_i;
      end
    end
  end

  assign beat_o = beat_q;

endmodule

// File: rtl/sum_of_squares_acc.sv
// Streaming sum of squares per VEC_LEN-sample vector; SOS_SATURATE_EN clamps instead of wrapping.
module sum_of_squares_acc
  import sos_pkg::*;
#(
  parameter int unsigned DATA_W  = SOS_DATA_W,
  parameter int unsigned VEC_LEN = 4,
  parameter int unsigned ACC_W   = SOS_ACC_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic                     data_valid,
  output logic [ACC_W-1:0]         sum_out,
  output logic                     sum_valid,
  output logic                     sum_ovf
);

  localparam int unsigned      IDX_W    = idx_w(VEC_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

  logic [IDX_W-1:0] idx_q, idx_d;
  sq_beat_t         beat;
  logic [ACC_W-1:0] sq_w;
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] sum_out_q;
  logic             sum_valid_q, sum_ovf_q;

  always_comb begin
    idx_d = idx_q;
    if (data_valid) idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
  end

  square_stage #(.DATA_W(DATA_W)) u_square (
    .clk_i   (clock),
    .rst_i   (reset),
    .data_i  (data_in),
    .valid_i (data_valid),
    .first_i (idx_q == '0),
    .last_i  (idx_q == LAST_IDX),
    .beat_o  (beat)
  );

  assign sq_w    = ACC_W'(beat.sq);
  assign sum_ext = {1'b0, acc_q} + {1'b0, sq_w};

  // A first element reloads rather than adds, so consecutive vectors need no bubble.
  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (beat.vld) begin
      if (beat.first) begin
        acc_d = sq_w;
        ovf_d = 1'b0;
      end else begin
        ovf_d = ovf_q | sum_ext[ACC_W];
`ifdef SOS_SATURATE_EN
        acc_d = ovf_d ? '1 : sum_ext[ACC_W-1:0];
`else
        acc_d = sum_ext[ACC_W-1:0];
`endif
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q       <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      sum_out_q   <= '0;
      sum_valid_q <= 1'b0;
      sum_ovf_q   <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      sum_valid_q <= beat.vld & beat.last;
      if (beat.vld && beat.last) begin
        sum_out_q <= acc_d;
        sum_ovf_q <= ovf_d;
      end
    end
  end

  assign sum_out   = sum_out_q;
  assign sum_valid = sum_valid_q;
  assign sum_ovf   = sum_ovf_q;

endmodule

// File: tb/tb_sum_of_squares_acc.sv
// Directed bench for sum_of_squares_acc (VEC_LEN=4 and VEC_LEN=1 instances).
module tb_sum_of_squares_acc;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic signed [15:0] data_in = '0;
  logic               data_valid = 1'b0;
  logic [31:0]        sum_out, sum1_out;
  logic               sum_valid, sum_ovf, sum1_valid, sum1_ovf;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  int unsigned cyc = 0;
  int unsigned last_put;

  int unsigned pulse_cyc[$];
  logic [31:0] pulse_sum[$];
  logic        pulse_ovf[$];

  sum_of_squares_acc #(.DATA_W(16), .VEC_LEN(4), .ACC_W(32)) u_dut (
    .clock      (clock),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .sum_out    (sum_out),
    .sum_valid  (sum_valid),
    .sum_ovf    (sum_ovf)
  );

  sum_of_squares_acc #(.DATA_W(16), .VEC_LEN(1), .ACC_W(32)) u_dut1 (
    .clock      (clock),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .sum_out    (sum1_out),
    .sum_valid  (sum1_valid),
    .sum_ovf    (sum1_ovf)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (sum_valid) begin
      pulse_cyc.push_back(cyc);
      pulse_sum.push_back(sum_out);
      pulse_ovf.push_back(sum_ovf);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  task automatic put(input logic v, input int d);
    @(negedge clock);
    data_valid = v;
    data_in    = 16'(d);
    if (v) last_put = cyc;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) put(1'b0, 0);
  endtask

  task automatic clear_log();
    pulse_cyc.delete();
    pulse_sum.delete();
    pulse_ovf.delete();
  endtask

  task automatic chk_pulse(input string tag, input int unsigned idx,
                           input logic [31:0] exp_sum, input logic exp_ovf);
    if (idx < pulse_sum.size()) begin
      chk({tag, "_sum"}, pulse_sum[idx], exp_sum);
      chk({tag, "_ovf"}, pulse_ovf[idx], exp_ovf);
    end else begin
      chk({tag, "_present"}, idx, pulse_sum.size());
    end
  endtask

  initial begin
    int unsigned p0;
    logic [31:0] t2_exp;

    repeat (2) @(negedge clock);
    chk("rst_sum", sum_out, 32'd0);
    chk("rst_valid", sum_valid, 1'b0);
    chk("rst_ovf", sum_ovf, 1'b0);
    reset = 1'b0;
    idle(2);
    clear_log();

    // T1: {3,4,0,0} -> 25, pulse two cycles after the last sample
    put(1, 3); put(1, 4); put(1, 0); put(1, 0);
    p0 = last_put;
    idle(5);
    chk("t1_npulse", pulse_sum.size(), 1);
    chk_pulse("t1", 0, 32'd25, 1'b0);
    if (pulse_cyc.size() > 0) chk("t1_latency", pulse_cyc[0] - p0, 2);
    clear_log();

    // T2: four full-scale negatives
    for (int i = 0; i < 4; i++) put(1, -32768);
    idle(5);
`ifdef SOS_SATURATE_EN
    t2_exp = 32'hFFFF_FFFF;
`else
    t2_exp = 32'h0000_0000;
`endif
    chk("t2_npulse", pulse_sum.size(), 1);
    chk_pulse("t2", 0, t2_exp, 1'b1);
    clear_log();

    // T3: back-to-back vectors, no contamination of the second sum
    put(1, 1); put(1, 2); put(1, 3); put(1, 4);
    for (int i = 0; i < 4; i++) put(1, -1);
    idle(5);
    chk("t3_npulse", pulse_sum.size(), 2);
    chk_pulse("t3a", 0, 32'd30, 1'b0);
    chk_pulse("t3b", 1, 32'd4, 1'b0);
    if (pulse_cyc.size() > 1) chk("t3_spacing", pulse_cyc[1] - pulse_cyc[0], 4);
    clear_log();

    // T4: gaps inside the vector; previous sum held meanwhile
    put(1, 5); put(0, 0); put(0, 0);
    chk("t4_hold_prev", sum_out, 32'd4);
    put(1, 6); put(0, 0); put(1, 7); put(1, 8);
    idle(5);
    chk("t4_npulse", pulse_sum.size(), 1);
    chk_pulse("t4", 0, 32'd174, 1'b0);
    chk("t4_hold", sum_out, 32'd174);
    clear_log();

    // T5: mid-vector reset discards the partial vector
    put(1, 9); put(1, 9);
    @(negedge clock);
    reset = 1'b1; data_valid = 1'b0;
    @(negedge clock);
    chk("t5_rst_sum", sum_out, 32'd0);
    chk("t5_rst_valid", sum_valid, 1'b0);
    chk("t5_rst_ovf", sum_ovf, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    idle(4);
    chk("t5_nopulse", pulse_sum.size(), 0);
    for (int i = 0; i < 4; i++) put(1, 1);
    idle(5);
    chk("t5_npulse", pulse_sum.size(), 1);
    chk_pulse("t5", 0, 32'd4, 1'b0);
    clear_log();

    // T6: VEC_LEN=1 instance, one pulse per sample
    put(1, -7); put(1, 0); put(1, 32767);
    chk("t6a_valid", sum1_valid, 1'b1);
    chk("t6a_sum", sum1_out, 32'd49);
    put(0, 0);
    chk("t6b_valid", sum1_valid, 1'b1);
    chk("t6b_sum", sum1_out, 32'd0);
    put(0, 0);
    chk("t6c_valid", sum1_valid, 1'b1);
    chk("t6c_sum", sum1_out, 32'd1073676289);
    chk("t6c_ovf", sum1_ovf, 1'b0);
    put(0, 0);
    chk("t6d_valid", sum1_valid, 1'b0);
    chk("t6d_hold", sum1_out, 32'd1073676289);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
